dma_stride_engine: RTL and testbench
====================================

DMA_STRIDE_ENGINE -- requirements
Module: dma_stride_engine

Interface
REQ-001 SHALL have parameter MEM_AW, default 9, local-memory word-address width.
REQ-002 SHALL have parameter LEN_W, default 10, line-length and line-count width.
REQ-003 SHALL have parameter MAX_BURST, default 256, largest bus burst in words, power of two, at most 256.
REQ-004 SHALL have ports: clock in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-005 SHALL have CPU ports: ci_valid in 1; ci_we in 1; ci_sel in 4, register select; ci_wdata in 32; ci_rdata out 32; irq out 1.
REQ-006 SHALL have memory ports: mem_addr out MEM_AW; mem_rdata in 32, asynchronous read; mem_wdata out 32; mem_we out 1.
REQ-007 SHALL have bus outputs: bus_request 1; address_data_out 32; byte_enables_out 4; burst_size_out 8; read_n_write_out 1; begin_transaction_out 1; end_transaction_out 1; data_valid_out 1.
REQ-008 SHALL have bus inputs: bus_grant 1; address_data_in 32; end_transaction_in 1; data_valid_in 1; busy_in 1; error_in 1.

Function
REQ-009 SHALL map ci_sel to registers: 1 bus start (32b); 2 mem start (MEM_AW); 3 line length in words (LEN_W); 4 burst length minus 1 (8b); 5 control; 6 status; 7 line count (LEN_W); 8 bus line stride in bytes (32b).
REQ-010 SHALL decode control as: bit0 start, self-clearing; bit1 direction, 1 = bus->memory, 0 = memory->bus; bit2 irq enable.
REQ-011 SHALL decode status as: bit0 busy; bit1 done; bit2 error; a write of 1 to bit1 or bit2 clears that bit.
REQ-012 SHALL drive ci_rdata with the selected register when ci_valid=1 and ci_we=0, and drive 0 otherwise or for an unmapped select.
REQ-013 SHALL ignore CPU writes to registers 1-4, 7 and 8 while busy=1.
REQ-014 SHALL ignore a start when line length or line count is 0, leaving status unchanged.
REQ-015 SHALL use FSM states IDLE, REQUEST, INIT, READ, WRITE, NEXT, CLOSE.
REQ-016 SHALL, on an accepted start in IDLE, set busy=1, clear done, load cursors (bus address, mem address, line base, remaining words, remaining lines) and enter REQUEST on the next cycle.
REQ-017 SHALL hold bus_request=1 only in REQUEST and enter INIT in the cycle after bus_grant=1.
REQ-018 SHALL drive, in INIT for one cycle: begin_transaction_out=1; read_n_write_out=direction; byte_enables_out=4'hF; address_data_out = byte-reversed bus address; burst_size_out = min(burst, words remaining in line) - 1.
REQ-019 SHALL drive every bus output to 0 outside the states that assert it.
REQ-020 SHALL, in READ, assert mem_we=1 and mem_wdata=address_data_in for each cycle with data_valid_in=1; each such beat advances mem address by 1, bus address by 4 and decrements remaining words.
REQ-021 SHALL, in WRITE, assert data_valid_out=1 with address_data_out=mem_rdata; a beat completes and advances the cursors only in a cycle with busy_in=0.
REQ-022 SHALL end the write burst after its last beat, asserting end_transaction_out=1 for one cycle in NEXT.
REQ-023 SHALL end the read burst on end_transaction_in=1 and enter NEXT without driving end_transaction_out.
REQ-024 SHALL, in NEXT, go to REQUEST when line words remain.
REQ-025 SHALL, in NEXT, when the line is exhausted and lines remain, set line base += stride, bus address = new line base, reload remaining words and go to REQUEST.
REQ-026 SHALL, in NEXT, after the final line, go to IDLE with busy=0 and done=1.
REQ-027 SHALL wrap mem address modulo 2^MEM_AW and bus address modulo 2^32.
REQ-028 SHALL, on error_in=1 in INIT, READ or WRITE, enter CLOSE, drive end_transaction_out=1 for one cycle, then go to IDLE with busy=0, error=1 and done=0.
REQ-029 SHALL hold irq=1 while irq enable=1 and (done or error)=1.
REQ-030 SHALL give error priority over a data beat and over end_transaction_in in the same cycle.
REQ-031 SHALL make a CPU clear of done/error coinciding with a new set leave the bit set.

Reset
REQ-032 SHALL, on reset=1 (including mid-transfer), clear all registers and cursors to 0, enter IDLE and drive every output to 0 from the next cycle.

Verification
REQ-033 SHALL pass: read, line length 8, count 1, burst 3, bus start 0x100, mem start 0 -> two bursts (4,4), burst_size_out 3 both times, second address byte-reversed 0x110, mem words 0-7 written, done=1.
REQ-034 SHALL pass: write, length 5, count 3, stride 0x40, burst 15 -> three bursts of 5 at 0x0, 0x40, 0x80, burst_size_out 4, 15 mem words read in order.
REQ-035 SHALL pass: write with busy_in high on beats 2-3 -> data_valid_out held with the same data, no cursor advance, 4 beats total.
REQ-036 SHALL pass: error_in during beat 2 of read -> CLOSE, end_transaction_out one cycle, status=3'b100, irq=1 when enabled.
REQ-037 SHALL pass: mem start 2^MEM_AW-2, length 4 -> mem addresses wrap to 0 and 1.
REQ-038 SHALL pass: reset mid-burst -> all outputs 0 the next cycle; start with length 0 -> status remains 0.

Source files
------------

// File: rtl/dma_stride_engine.sv
// ---------------------------------------------------------------------------
// dma_stride_engine
//
// Moves a 2-D block between a small local word memory and a 32-bit burst bus.
// The block is line_count lines of line_length words. Consecutive lines sit
// line_stride bytes apart on the bus and are packed back-to-back in local
// memory. Each line is split into bus bursts of at most (burst+1) words.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   ci_*                 CPU register port; ci_rdata is valid combinationally
//                        during a read (ci_valid=1, ci_we=0)
//   irq                  level interrupt: irq enable and (done or error)
//   mem_*                local memory: word address, async read data,
//                        write data and write enable
//   bus_request ..       bus master outputs (request, multiplexed
//   data_valid_out       address/data, byte enables, burst size, direction,
//                        begin/end of transaction, write-data valid)
//   bus_grant ..         bus inputs (grant, read data, end of transaction,
//   error_in             read-data valid, slave busy, error)
// ---------------------------------------------------------------------------
module dma_stride_engine #(
   parameter int MEM_AW    = 9,
   parameter int LEN_W     = 10,
   parameter int MAX_BURST = 256
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ci_valid,
   input  logic              ci_we,
   input  logic [3:0]        ci_sel,
   input  logic [31:0]       ci_wdata,
   output logic [31:0]       ci_rdata,
   output logic              irq,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              bus_request,
   output logic [31:0]       address_data_out,
   output logic [3:0]        byte_enables_out,
   output logic [7:0]        burst_size_out,
   output logic              read_n_write_out,
   output logic              begin_transaction_out,
   output logic              end_transaction_out,
   output logic              data_valid_out,
   input  logic              bus_grant,
   input  logic [31:0]       address_data_in,
   input  logic              end_transaction_in,
   input  logic              data_valid_in,
   input  logic              busy_in,
   input  logic              error_in
);

   typedef enum logic [2:0] {IDLE, REQUEST, INIT, READ, WRITE, NEXT, CLOSE} state_t;

   state_t            state_q;
   logic [31:0]       busStart_q;
   logic [MEM_AW-1:0] memStart_q;
   logic [LEN_W-1:0]  lineLen_q;
   logic [7:0]        burst_q;
   logic              dir_q;
   logic              irqEn_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [LEN_W-1:0]  lineCount_q;
   logic [31:0]       stride_q;

   logic              xferDir_q;
   logic [31:0]       busAddr_q;
   logic [MEM_AW-1:0] memAddr_q;
   logic [31:0]       lineBase_q;
   logic [LEN_W-1:0]  remWords_q;
   logic [LEN_W-1:0]  remLines_q;
   logic [8:0]        beatsLeft_q;

   logic [8:0]        burstCap_d;
   logic [8:0]        burstLen_d;
   logic [31:0]       lineBase_d;
   logic              startOk;

   // Words in the next burst: the programmed burst, clamped to the largest
   // bus burst and to what is left of the current line.
   always_comb begin
      burstCap_d = {1'b0, burst_q} + 9'd1;
      if (burstCap_d > 9'(MAX_BURST))
         burstCap_d = 9'(MAX_BURST);
      burstLen_d = burstCap_d;
      if (32'(remWords_q) < 32'(burstCap_d))
         burstLen_d = 9'(remWords_q);
   end

   assign lineBase_d = lineBase_q + stride_q;

   // A start only counts from IDLE with a non-empty block; otherwise nothing
   // about the status changes.
   assign startOk = ci_valid && ci_we && (ci_sel == 4'd5) && ci_wdata[0] &&
                    (state_q == IDLE) && (lineLen_q != '0) && (lineCount_q != '0);

   // Register file and transfer sequencer. The FSM section comes after the
   // CPU write section so a hardware set of done/error wins over a CPU clear
   // landing in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         busStart_q  <= '0;
         memStart_q  <= '0;
         lineLen_q   <= '0;
         burst_q     <= '0;
         dir_q       <= 1'b0;
         irqEn_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         lineCount_q <= '0;
         stride_q    <= '0;
         xferDir_q   <= 1'b0;
         busAddr_q   <= '0;
         memAddr_q   <= '0;
         lineBase_q  <= '0;
         remWords_q  <= '0;
         remLines_q  <= '0;
         beatsLeft_q <= '0;
      end else begin
         if (ci_valid && ci_we) begin
            case (ci_sel)
               4'd1: if (!busy_q) busStart_q  <= ci_wdata;
               4'd2: if (!busy_q) memStart_q  <= ci_wdata[MEM_AW-1:0];
               4'd3: if (!busy_q) lineLen_q   <= ci_wdata[LEN_W-1:0];
               4'd4: if (!busy_q) burst_q     <= ci_wdata[7:0];
               4'd5: begin
                  dir_q   <= ci_wdata[1];
                  irqEn_q <= ci_wdata[2];
               end
               4'd6: begin
                  if (ci_wdata[1]) done_q <= 1'b0;
                  if (ci_wdata[2]) err_q  <= 1'b0;
               end
               4'd7: if (!busy_q) lineCount_q <= ci_wdata[LEN_W-1:0];
               4'd8: if (!busy_q) stride_q    <= ci_wdata;
               default: ;
            endcase
         end

         case (state_q)
            IDLE: begin
               if (startOk) begin
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  xferDir_q  <= ci_wdata[1];
                  busAddr_q  <= busStart_q;
                  lineBase_q <= busStart_q;
                  memAddr_q  <= memStart_q;
                  remWords_q <= lineLen_q;
                  remLines_q <= lineCount_q;
                  state_q    <= REQUEST;
               end
            end
            REQUEST: begin
               if (bus_grant) state_q <= INIT;
            end
            INIT: begin
               if (error_in) begin
                  state_q <= CLOSE;
               end else begin
                  beatsLeft_q <= burstLen_d;
                  state_q     <= xferDir_q ? READ : WRITE;
               end
            end
            READ: begin
               if (error_in) begin
                  state_q <= CLOSE;
               end else begin
                  if (data_valid_in) begin
                     memAddr_q  <= memAddr_q + 1'b1;
                     busAddr_q  <= busAddr_q + 32'd4;
                     remWords_q <= remWords_q - 1'b1;
                  end
                  if (end_transaction_in) state_q <= NEXT;
               end
            end
            WRITE: begin
               if (error_in) begin
                  state_q <= CLOSE;
               end else if (!busy_in) begin
                  memAddr_q   <= memAddr_q + 1'b1;
                  busAddr_q   <= busAddr_q + 32'd4;
                  remWords_q  <= remWords_q - 1'b1;
                  beatsLeft_q <= beatsLeft_q - 9'd1;
                  if (beatsLeft_q == 9'd1) state_q <= NEXT;
               end
            end
            NEXT: begin
               if (remWords_q != '0) begin
                  state_q <= REQUEST;
               end else if (remLines_q > {{(LEN_W-1){1'b0}}, 1'b1}) begin
                  lineBase_q <= lineBase_d;
                  busAddr_q  <= lineBase_d;
                  remWords_q <= lineLen_q;
                  remLines_q <= remLines_q - 1'b1;
                  state_q    <= REQUEST;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            CLOSE: begin
               busy_q  <= 1'b0;
               err_q   <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Bus and memory strobes decoded from the current state. Error takes
   // priority over a read beat, so the memory write is suppressed then.
   always_comb begin
      bus_request           = 1'b0;
      address_data_out      = '0;
      byte_enables_out      = '0;
      burst_size_out        = '0;
      read_n_write_out      = 1'b0;
      begin_transaction_out = 1'b0;
      end_transaction_out   = 1'b0;
      data_valid_out        = 1'b0;
      mem_we                = 1'b0;
      mem_wdata             = '0;
      case (state_q)
         REQUEST: bus_request = 1'b1;
         INIT: begin
            begin_transaction_out = 1'b1;
            read_n_write_out      = xferDir_q;
            byte_enables_out      = 4'hF;
            address_data_out      = {busAddr_q[7:0], busAddr_q[15:8],
                                     busAddr_q[23:16], busAddr_q[31:24]};
            burst_size_out        = 8'(burstLen_d - 9'd1);
         end
         READ: begin
            if (data_valid_in && !error_in) begin
               mem_we    = 1'b1;
               mem_wdata = address_data_in;
            end
         end
         WRITE: begin
            data_valid_out   = 1'b1;
            address_data_out = mem_rdata;
         end
         NEXT:  end_transaction_out = !xferDir_q;
         CLOSE: end_transaction_out = 1'b1;
         default: ;
      endcase
   end

   assign mem_addr = memAddr_q;
   assign irq      = irqEn_q && (done_q || err_q);

   // CPU read mux; the start bit always reads back as 0.
   always_comb begin
      ci_rdata = '0;
      if (ci_valid && !ci_we) begin
         case (ci_sel)
            4'd1:    ci_rdata = busStart_q;
            4'd2:    ci_rdata = 32'(memStart_q);
            4'd3:    ci_rdata = 32'(lineLen_q);
            4'd4:    ci_rdata = {24'd0, burst_q};
            4'd5:    ci_rdata = {29'd0, irqEn_q, dir_q, 1'b0};
            4'd6:    ci_rdata = {29'd0, err_q, done_q, busy_q};
            4'd7:    ci_rdata = 32'(lineCount_q);
            4'd8:    ci_rdata = stride_q;
            default: ci_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_stride_engine.sv
// ---------------------------------------------------------------------------
// tb_dma_stride_engine
//
// Directed bench for dma_stride_engine. A register-access table exercises the
// CPU port; hand-written sequences act as bus slave for read/write transfers,
// stalls, errors, memory address wrap and reset mid-burst. The local memory
// is modelled here and preloaded with a known address pattern.
// ---------------------------------------------------------------------------
module tb_dma_stride_engine;

   logic        clock = 1'b0;
   logic        reset;
   logic        ci_valid, ci_we;
   logic [3:0]  ci_sel;
   logic [31:0] ci_wdata, ci_rdata;
   logic        irq;
   logic [8:0]  mem_addr;
   logic [31:0] mem_rdata, mem_wdata;
   logic        mem_we;
   logic        bus_request;
   logic [31:0] address_data_out;
   logic [3:0]  byte_enables_out;
   logic [7:0]  burst_size_out;
   logic        read_n_write_out, begin_transaction_out, end_transaction_out, data_valid_out;
   logic        bus_grant;
   logic [31:0] address_data_in;
   logic        end_transaction_in, data_valid_in, busy_in, error_in;

   int passCount = 0;
   int checkCount = 0;

   logic [31:0] mem [0:511];
   logic        memInit = 1'b1;

   typedef struct {
      logic        valid;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] expRd;
   } regVec_t;

   regVec_t vecs [19];

   dma_stride_engine #(.MEM_AW(9), .LEN_W(10), .MAX_BURST(256)) dut (
      .clock(clock), .reset(reset),
      .ci_valid(ci_valid), .ci_we(ci_we), .ci_sel(ci_sel), .ci_wdata(ci_wdata),
      .ci_rdata(ci_rdata), .irq(irq),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .bus_request(bus_request), .address_data_out(address_data_out),
      .byte_enables_out(byte_enables_out), .burst_size_out(burst_size_out),
      .read_n_write_out(read_n_write_out), .begin_transaction_out(begin_transaction_out),
      .end_transaction_out(end_transaction_out), .data_valid_out(data_valid_out),
      .bus_grant(bus_grant), .address_data_in(address_data_in),
      .end_transaction_in(end_transaction_in), .data_valid_in(data_valid_in),
      .busy_in(busy_in), .error_in(error_in)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] pat(input logic [8:0] a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   // Local memory model: async read, synchronous write, one-shot preload.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clock) begin
      if (memInit) begin
         for (int i = 0; i < 512; i++) mem[i] <= pat(9'(i));
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   task automatic applyStimulus(input regVec_t v, input int idx);
      @(negedge clock);
      ci_valid = v.valid;
      ci_we    = v.we;
      ci_sel   = v.sel;
      ci_wdata = v.wdata;
      #1;
      checkOutput($sformatf("regVec%0d", idx), ci_rdata, v.expRd);
   endtask

   task automatic cpuWrite(input logic [3:0] sel, input logic [31:0] data);
      @(negedge clock);
      ci_valid = 1'b1; ci_we = 1'b1; ci_sel = sel; ci_wdata = data;
      @(negedge clock);
      ci_valid = 1'b0; ci_we = 1'b0;
   endtask

   task automatic expectReg(input string name, input logic [3:0] sel, input logic [31:0] expected);
      @(negedge clock);
      ci_valid = 1'b1; ci_we = 1'b0; ci_sel = sel;
      #1;
      checkOutput(name, ci_rdata, expected);
      ci_valid = 1'b0;
   endtask

   task automatic configure(input logic [31:0] busStart, input logic [31:0] memStart,
                            input logic [31:0] len, input logic [31:0] count,
                            input logic [31:0] burst, input logic [31:0] stride);
      cpuWrite(4'd1, busStart);
      cpuWrite(4'd2, memStart);
      cpuWrite(4'd3, len);
      cpuWrite(4'd4, burst);
      cpuWrite(4'd7, count);
      cpuWrite(4'd8, stride);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Ctl"}, 32'({mem_we, irq, bus_request, begin_transaction_out,
                  end_transaction_out, data_valid_out, read_n_write_out,
                  byte_enables_out, burst_size_out}), 32'd0);
      checkOutput({tag, "AddrData"}, address_data_out, 32'd0);
      checkOutput({tag, "MemWdata"}, mem_wdata, 32'd0);
      checkOutput({tag, "MemAddr"}, 32'(mem_addr), 32'd0);
   endtask

   // Waits (bounded) for a request, grants for one cycle and checks INIT.
   task automatic grantAndInit(input logic [31:0] expAddr, input logic [7:0] expSize, input logic expRnw);
      int cyc;
      cyc = 0;
      @(negedge clock);
      while (!bus_request && cyc < 50) begin
         @(negedge clock);
         cyc++;
      end
      checkOutput("busRequest", 32'(bus_request), 32'd1);
      bus_grant = 1'b1;
      @(negedge clock);
      bus_grant = 1'b0;
      #1;
      checkOutput("beginTxn", 32'(begin_transaction_out), 32'd1);
      checkOutput("initAddr", address_data_out, expAddr);
      checkOutput("initCtl", 32'({read_n_write_out, byte_enables_out, burst_size_out}),
                  32'({expRnw, 4'hF, expSize}));
   endtask

   task automatic serveRead(input logic [8:0] memStart, input int beats, input logic [31:0] dataBase);
      for (int i = 0; i < beats; i++) begin
         @(negedge clock);
         data_valid_in      = 1'b1;
         address_data_in    = dataBase + 32'(i);
         end_transaction_in = (i == beats - 1);
         #1;
         checkOutput("readMemWe", 32'(mem_we), 32'd1);
         checkOutput("readMemAddr", 32'(mem_addr), 32'(9'(memStart + 9'(i))));
         checkOutput("readMemData", mem_wdata, dataBase + 32'(i));
      end
      @(negedge clock);
      data_valid_in = 1'b0; end_transaction_in = 1'b0;
      #1;
      checkOutput("readNoEndOut", 32'(end_transaction_out), 32'd0);
   endtask

   // stallMask bit k: hold busy_in for one cycle before beat k completes.
   task automatic serveWrite(input logic [8:0] memStart, input int beats, input logic [15:0] stallMask);
      int   k;
      int   guard;
      logic stalled;
      k = 0; guard = 0; stalled = 1'b0;
      while (k < beats && guard < 200) begin
         @(negedge clock);
         guard++;
         busy_in = stallMask[k] && !stalled;
         #1;
         checkOutput("writeValid", 32'(data_valid_out), 32'd1);
         checkOutput("writeData", address_data_out, pat(9'(memStart + 9'(k))));
         checkOutput("writeMemAddr", 32'(mem_addr), 32'(9'(memStart + 9'(k))));
         if (busy_in) stalled = 1'b1;
         else begin
            stalled = 1'b0;
            k++;
         end
      end
      @(negedge clock);
      busy_in = 1'b0;
      #1;
      checkOutput("writeEndOut", 32'(end_transaction_out), 32'd1);
      checkOutput("writeDvoOff", 32'(data_valid_out), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1;
      ci_valid = 1'b0; ci_we = 1'b0; ci_sel = 4'd0; ci_wdata = 32'd0;
      bus_grant = 1'b0; address_data_in = 32'd0; end_transaction_in = 1'b0;
      data_valid_in = 1'b0; busy_in = 1'b0; error_in = 1'b0;

      vecs[0]  = '{1'b1, 1'b0, 4'd1, 32'h0,         32'h0};
      vecs[1]  = '{1'b1, 1'b1, 4'd1, 32'hDEAD_BEEF, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 4'd1, 32'h0,         32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 1'b1, 4'd2, 32'hFFFF_FFFF, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, 4'd2, 32'h0,         32'h0000_01FF};
      vecs[5]  = '{1'b1, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'h0};
      vecs[6]  = '{1'b1, 1'b0, 4'd3, 32'h0,         32'h0000_03FF};
      vecs[7]  = '{1'b1, 1'b1, 4'd4, 32'h0000_1234, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 4'd4, 32'h0,         32'h0000_0034};
      vecs[9]  = '{1'b1, 1'b1, 4'd7, 32'h0000_FFFF, 32'h0};
      vecs[10] = '{1'b1, 1'b0, 4'd7, 32'h0,         32'h0000_03FF};
      vecs[11] = '{1'b1, 1'b1, 4'd8, 32'h0000_0040, 32'h0};
      vecs[12] = '{1'b1, 1'b0, 4'd8, 32'h0,         32'h0000_0040};
      vecs[13] = '{1'b1, 1'b1, 4'd5, 32'h0000_0006, 32'h0};
      vecs[14] = '{1'b1, 1'b0, 4'd5, 32'h0,         32'h0000_0006};
      vecs[15] = '{1'b1, 1'b0, 4'd6, 32'h0,         32'h0};
      vecs[16] = '{1'b1, 1'b0, 4'd0, 32'h0,         32'h0};
      vecs[17] = '{1'b1, 1'b0, 4'd9, 32'h0,         32'h0};
      vecs[18] = '{1'b0, 1'b0, 4'd1, 32'h0,         32'h0};

      repeat (3) @(negedge clock);
      memInit = 1'b0;
      #1;
      checkAllZero("reset");
      reset = 1'b0;
      expectReg("resetStatus", 4'd6, 32'd0);

      $display("[TB] register access table");
      for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);
      @(negedge clock);
      ci_valid = 1'b0; ci_we = 1'b0;

      $display("[TB] strided write: 3 lines of 5, stride 0x40");
      configure(32'h0, 32'h10, 32'd5, 32'd3, 32'd15, 32'h40);
      cpuWrite(4'd5, 32'h1);
      grantAndInit(32'h0000_0000, 8'd4, 1'b0);
      serveWrite(9'h10, 5, 16'h0);
      grantAndInit(32'h4000_0000, 8'd4, 1'b0);
      serveWrite(9'h15, 5, 16'h0);
      grantAndInit(32'h8000_0000, 8'd4, 1'b0);
      serveWrite(9'h1A, 5, 16'h0);
      expectReg("stridedStatus", 4'd6, 32'h2);
      checkOutput("stridedIrqOff", 32'(irq), 32'd0);

      $display("[TB] write with slave stalls on beats 2-3");
      configure(32'h200, 32'h20, 32'd4, 32'd1, 32'd7, 32'h0);
      cpuWrite(4'd5, 32'h1);
      grantAndInit(32'h0002_0000, 8'd3, 1'b0);
      serveWrite(9'h20, 4, 16'h0006);
      expectReg("stallStatus", 4'd6, 32'h2);

      $display("[TB] read: line of 8 in bursts of 4");
      configure(32'h100, 32'h0, 32'd8, 32'd1, 32'd3, 32'h0);
      cpuWrite(4'd5, 32'h3);
      grantAndInit(32'h0001_0000, 8'd3, 1'b1);
      serveRead(9'd0, 4, 32'hA000_0000);
      grantAndInit(32'h1001_0000, 8'd3, 1'b1);
      serveRead(9'd4, 4, 32'hA000_0004);
      expectReg("readStatus", 4'd6, 32'h2);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("readMem%0d", i), mem[i], 32'hA000_0000 + 32'(i));

      $display("[TB] read with error on beat 2");
      configure(32'h300, 32'h40, 32'd4, 32'd1, 32'd3, 32'h0);
      cpuWrite(4'd5, 32'h7);
      grantAndInit(32'h0003_0000, 8'd3, 1'b1);
      @(negedge clock);
      data_valid_in = 1'b1; address_data_in = 32'h11;
      #1;
      checkOutput("errBeat1We", 32'(mem_we), 32'd1);
      @(negedge clock);
      data_valid_in = 1'b1; address_data_in = 32'h22; error_in = 1'b1;
      #1;
      checkOutput("errBeat2WeOff", 32'(mem_we), 32'd0);
      @(negedge clock);
      data_valid_in = 1'b0; error_in = 1'b0;
      #1;
      checkOutput("closeEndOut", 32'(end_transaction_out), 32'd1);
      @(negedge clock);
      #1;
      checkOutput("closeEndOnce", 32'(end_transaction_out), 32'd0);
      expectReg("errStatus", 4'd6, 32'h4);
      checkOutput("errIrq", 32'(irq), 32'd1);
      checkOutput("errMem40", mem[9'h40], 32'h11);
      checkOutput("errMem41", mem[9'h41], pat(9'h41));
      cpuWrite(4'd6, 32'h4);
      expectReg("errCleared", 4'd6, 32'h0);
      checkOutput("errIrqOff", 32'(irq), 32'd0);

      $display("[TB] read with local address wrap");
      configure(32'h0, 32'd510, 32'd4, 32'd1, 32'd3, 32'h0);
      cpuWrite(4'd5, 32'h3);
      grantAndInit(32'h0, 8'd3, 1'b1);
      serveRead(9'd510, 4, 32'hE000_0000);
      checkOutput("wrapMem510", mem[510], 32'hE000_0000);
      checkOutput("wrapMem511", mem[511], 32'hE000_0001);
      checkOutput("wrapMem0", mem[0], 32'hE000_0002);
      checkOutput("wrapMem1", mem[1], 32'hE000_0003);

      $display("[TB] reset mid-burst, then start with zero length");
      configure(32'h0, 32'h80, 32'd8, 32'd1, 32'd7, 32'h0);
      cpuWrite(4'd5, 32'h3);
      expectReg("busyStatus", 4'd6, 32'h1);
      cpuWrite(4'd3, 32'h7);
      expectReg("busyLenLocked", 4'd3, 32'd8);
      grantAndInit(32'h0, 8'd7, 1'b1);
      @(negedge clock);
      data_valid_in = 1'b1; address_data_in = 32'h55;
      #1;
      checkOutput("midBurstWe", 32'(mem_we), 32'd1);
      @(negedge clock);
      reset = 1'b1; data_valid_in = 1'b0;
      @(negedge clock);
      #1;
      checkAllZero("midReset");
      reset = 1'b0;
      expectReg("postResetLen", 4'd3, 32'd0);
      expectReg("postResetStatus", 4'd6, 32'd0);
      cpuWrite(4'd7, 32'd1);
      cpuWrite(4'd5, 32'h1);
      repeat (3) @(negedge clock);
      #1;
      checkOutput("zeroLenNoReq", 32'(bus_request), 32'd0);
      expectReg("zeroLenStatus", 4'd6, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
